mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges a fetch-side read port and a load/store port onto
// one sram-like memory port. Requests are granted combinationally; a grant
// that stalls on m_addr_ok is locked until its handshake. Owners of accepted
// requests are queued in order so responses are routed back to the right side.
//
// Build option: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
// toward the port not granted at the last handshake; otherwise data wins.
module mem_req_arbiter #(
  parameter int OQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load/store side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wen,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory port
  output logic        m_req,
  output logic        m_wr,
  output logic [3:0]  m_wen,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  // diagnostics
  output logic        err_orphan
);

  localparam int PW = $clog2(OQ_DEPTH);
  localparam int CW = $clog2(OQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(OQ_DEPTH);

  typedef enum logic { OWN_INST = 1'b0, OWN_DATA = 1'b1 } owner_e;
  typedef enum logic { ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1 } arb_state_e;

  arb_state_e      state_q, state_d;
  owner_e          lock_owner_q, lock_owner_d;
  owner_e          grant;
  owner_e          head_owner;
  owner_e          owner_mem [OQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            err_orphan_q;
  logic            fifo_full, fifo_empty;
  logic            handshake, pop;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e          last_grant_q;
`endif

  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign head_owner = owner_mem[rd_ptr_q];

  // Request out is suppressed whenever the owner queue is full, even if a
  // response drains an entry in the same cycle.
  assign m_req     = (inst_req | data_req | (state_q == ARB_LOCKED)) & ~fifo_full;
  assign handshake = m_req & m_addr_ok;
  assign pop       = m_data_ok & ~fifo_empty;

  // Grant selection: a locked grant is held, otherwise resolve by request mix.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant = OWN_INST;
    if (state_q == ARB_LOCKED) begin
      grant = lock_owner_q;
    end else if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (last_grant_q == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
      grant = OWN_DATA;
`endif
    end else if (data_req) begin
      grant = OWN_DATA;
    end
  end

  // Lock next-state: enter on a stalled request, leave on handshake.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    if (m_req) begin
      if (m_addr_ok) begin
        state_d = ARB_IDLE;
      end else begin
        state_d      = ARB_LOCKED;
        lock_owner_d = grant;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      lock_owner_q <= OWN_INST;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  // Request mux onto the shared port and address-phase acknowledgements.
  always_comb begin
    m_wr         = 1'b0;
    m_wen        = 4'b0000;
    m_size       = inst_size;
    m_addr       = inst_addr;
    m_wdata      = 32'h0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (grant == OWN_DATA) begin
      m_wr         = data_wr;
      m_wen        = data_wen;
      m_size       = data_size;
      m_addr       = data_addr;
      m_wdata      = data_wdata;
      data_addr_ok = handshake;
    end else begin
      inst_addr_ok = handshake;
    end
  end

  // Response routing: the queue head decides which side sees data_ok.
  assign inst_data_ok = pop & (head_owner == OWN_INST);
  assign data_data_ok = pop & (head_owner == OWN_DATA);
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;
  assign err_orphan   = err_orphan_q;

  // Owner queue pointers, occupancy and the sticky orphan flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (handshake) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({handshake, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (m_data_ok && fifo_empty) err_orphan_q <= 1'b1;
    end
  end

  // Owner queue storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read while count_q says they are valid.
    if (handshake) owner_mem[wr_ptr_q] <= grant;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-granted port, updated only when a request is actually accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_q <= OWN_INST;
    end else if (handshake) begin
      last_grant_q <= grant;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter (default OQ_DEPTH=2). Inputs change
// 1 ns after the rising edge; outputs are compared 1 ns later.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [1:0]  inst_size;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wen;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        err_orphan;

  int n_checks = 0;
  int n_err    = 0;

  mem_req_arbiter #(.OQ_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_wen(m_wen), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Expected grant sequence under a constant two-sided request (1 = data).
`ifdef ARB_ROUND_ROBIN_EN
  logic exp_gd [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
  logic exp_gd [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

  initial begin
    resetn     = 1'b0;
    inst_req   = 1'b0; inst_addr = 32'h0; inst_size = 2'd2;
    data_req   = 1'b0; data_wr = 1'b0; data_wen = 4'h0; data_size = 2'd2;
    data_addr  = 32'h0; data_wdata = 32'h0;
    m_addr_ok  = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;

    // Reset state
    do_reset();
    #1;
    check("rst_m_req", m_req, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    check("rst_inst_data_ok", inst_data_ok, 0);
    check("rst_data_data_ok", data_data_ok, 0);
    check("rst_err_orphan", err_orphan, 0);

    // Orphan response with an empty queue
    tick();
    m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    check("orph_inst_data_ok", inst_data_ok, 0);
    check("orph_data_data_ok", data_data_ok, 0);
    check("orph_inst_rdata", inst_rdata, 32'hDEAD_BEEF);
    check("orph_data_rdata", data_rdata, 32'hDEAD_BEEF);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("orph_flag_set", err_orphan, 1);
    tick();
    tick();
    check("orph_flag_held", err_orphan, 1);
    do_reset();
    #1;
    check("orph_flag_cleared", err_orphan, 0);

    // Both sides request continuously, memory always ready
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000; data_wr = 1'b0;
    m_addr_ok = 1'b1; m_data_ok = 1'b0;
    #1;
    check("both_c0_data_addr_ok", data_addr_ok, exp_gd[0]);
    check("both_c0_inst_addr_ok", inst_addr_ok, !exp_gd[0]);
    check("both_c0_m_addr", m_addr, exp_gd[0] ? 32'h2000 : 32'h1000);
    for (int i = 1; i < 4; i++) begin
      tick();
      m_data_ok = 1'b1; m_rdata = 32'h100 + i;
      #1;
      check("both_data_addr_ok", data_addr_ok, exp_gd[i]);
      check("both_inst_addr_ok", inst_addr_ok, !exp_gd[i]);
      check("both_m_addr", m_addr, exp_gd[i] ? 32'h2000 : 32'h1000);
      check("both_data_data_ok", data_data_ok, exp_gd[i-1]);
      check("both_inst_data_ok", inst_data_ok, !exp_gd[i-1]);
    end
    tick();
    inst_req = 1'b0; data_req = 1'b0; m_data_ok = 1'b1;
    #1;
    check("drain_m_req", m_req, 0);
    check("drain_data_data_ok", data_data_ok, exp_gd[3]);
    check("drain_inst_data_ok", inst_data_ok, !exp_gd[3]);

    // Stalled inst request locks the grant while data arrives
    tick();
    m_data_ok = 1'b0; m_addr_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_4000; inst_size = 2'd1;
    data_wr = 1'b1; data_wen = 4'hF; data_wdata = 32'h5555_AAAA; data_addr = 32'h0000_5000;
    #1;
    check("lock_c1_m_req", m_req, 1);
    check("lock_c1_m_addr", m_addr, 32'h4000);
    check("lock_c1_inst_addr_ok", inst_addr_ok, 0);
    check("inst_grant_m_wr", m_wr, 0);
    check("inst_grant_m_wen", m_wen, 0);
    check("inst_grant_m_wdata", m_wdata, 0);
    check("inst_grant_m_size", m_size, 1);
    tick();
    data_req = 1'b1;
    #1;
    check("lock_c2_m_addr", m_addr, 32'h4000);
    check("lock_c2_data_addr_ok", data_addr_ok, 0);
    tick();
    check("lock_c3_m_addr", m_addr, 32'h4000);
    check("lock_c3_inst_addr_ok", inst_addr_ok, 0);
    tick();
    m_addr_ok = 1'b1;
    #1;
    check("lock_c4_inst_addr_ok", inst_addr_ok, 1);
    check("lock_c4_data_addr_ok", data_addr_ok, 0);
    tick();
    inst_req = 1'b0;
    #1;
    check("lock_c5_data_addr_ok", data_addr_ok, 1);
    check("lock_c5_m_wr", m_wr, 1);
    check("lock_c5_m_addr", m_addr, 32'h5000);

    // Queue full with I,D outstanding: third request held off
    tick();
    #1;
    check("full_m_req", m_req, 0);
    check("full_data_addr_ok", data_addr_ok, 0);
    tick();
    data_req = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    check("resp1_inst_data_ok", inst_data_ok, 1);
    check("resp1_data_data_ok", data_data_ok, 0);
    check("resp1_inst_rdata", inst_rdata, 32'h1234_5678);
    tick();
    m_rdata = 32'hCAFE_F00D;
    #1;
    check("resp2_data_data_ok", data_data_ok, 1);
    check("resp2_inst_data_ok", inst_data_ok, 0);
    check("resp2_data_rdata", data_rdata, 32'hCAFE_F00D);

    // Full queue with a response and a new request in the same cycle
    tick();
    m_data_ok = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000;
    #1;
    check("fill1_data_addr_ok", data_addr_ok, 1);
    tick();
    check("fill2_data_addr_ok", data_addr_ok, 1);
    tick();
    m_data_ok = 1'b1;
    #1;
    check("fullpop_m_req", m_req, 0);
    check("fullpop_data_addr_ok", data_addr_ok, 0);
    check("fullpop_data_data_ok", data_data_ok, 1);
    tick();
    m_data_ok = 1'b0;
    #1;
    check("after_pop_m_req", m_req, 1);
    check("after_pop_data_addr_ok", data_addr_ok, 1);
    tick();
    check("refull_m_req", m_req, 0);

    // Reset with two outstanding owners
    data_req = 1'b0; m_addr_ok = 1'b0;
    do_reset();
    #1;
    check("rst2_m_req", m_req, 0);
    check("rst2_err_orphan", err_orphan, 0);
    check("rst2_data_data_ok", data_data_ok, 0);
    tick();
    m_data_ok = 1'b1;
    #1;
    check("stale_inst_data_ok", inst_data_ok, 0);
    check("stale_data_data_ok", data_data_ok, 0);
    tick();
    m_data_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0010; data_size = 2'd0;
    data_addr = 32'h8000_0001; data_wdata = 32'h0000_AB00; m_addr_ok = 1'b1;
    #1;
    check("stale_err_orphan", err_orphan, 1);
    check("sb_m_req", m_req, 1);
    check("sb_m_wr", m_wr, 1);
    check("sb_m_wen", m_wen, 4'b0010);
    check("sb_m_size", m_size, 0);
    check("sb_m_addr", m_addr, 32'h8000_0001);
    check("sb_m_wdata", m_wdata, 32'h0000_AB00);
    check("sb_data_addr_ok", data_addr_ok, 1);
    tick();
    data_wr = 1'b0; data_wen = 4'h0;
    #1;
    check("post_sb_m_req", m_req, 1);
    check("post_sb_m_wr", m_wr, 0);
    tick();
    check("post_sb_full", m_req, 0);
    check("post_sb_err_orphan", err_orphan, 1);
    do_reset();
    #1;
    check("rst3_err_orphan", err_orphan, 0);
    check("rst3_m_req", m_req, 1);
    check("rst3_data_addr_ok", data_addr_ok, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
